// File: rtl/perspective_divide.sv
// Perspective divide for the vertex pipeline. It takes one clip-space vertex
// (x, y, z, w) in signed Q16.16, computes q = floor(2^32 / w) with a serial
// restoring divider, scales x/y/z by q to NDC, and maps NDC x/y to screen
// pixels. z/w is passed on as depth. Vertices outside the view volume, and
// vertices with w < 1.0, are flagged as clipped.
module perspective_divide #(
  parameter int unsigned SCREEN_W = 320,
  parameter int unsigned SCREEN_H = 240,
  parameter int unsigned PX_W     = 9,
  parameter int unsigned PY_W     = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              valid_in,
  input  logic [31:0]       vec_in [3:0],
  output logic              ready_out,
  output logic              valid_out,
  output logic [PX_W-1:0]   px_out,
  output logic [PY_W-1:0]   py_out,
  output logic [31:0]       depth_out,
  output logic              clipped_out
);

  localparam int unsigned       DIV_STEPS = 33;
  localparam int unsigned       CNT_W     = 6;
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DIV_STEPS - 1);
  localparam logic signed [31:0] ONE      = 32'sh0001_0000;
  localparam logic [47:0]       HALF_W    = 48'(SCREEN_W / 2);
  localparam logic [47:0]       HALF_H    = 48'(SCREEN_H / 2);
  localparam logic [31:0]       PX_MAX    = 32'(SCREEN_W - 1);
  localparam logic [31:0]       PY_MAX    = 32'(SCREEN_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    MULT,
    SCALE
  } state_t;

  state_t state, state_nxt;

  // Captured vertex and divider state
  logic signed [31:0] x_r, y_r, z_r;
  logic [31:0]        w_r;
  logic               near_r;
  logic [31:0]        rem_r;
  logic [32:0]        quot_r;
  logic [CNT_W-1:0]   cnt_r;
  logic signed [31:0] ndc_x_r, ndc_y_r, ndc_z_r;

  logic               accept_c;
  logic [32:0]        trial_c;
  logic               div_ge_c;
  logic [31:0]        rem_nxt_c;
  logic signed [17:0] recip_c;
  logic signed [49:0] prod_x_c, prod_y_c, prod_z_c;
  logic signed [31:0] ndc_x_c, ndc_y_c, ndc_z_c;
  logic [31:0]        sum_x_c, sum_y_c;
  logic [47:0]        scl_x_c, scl_y_c;
  logic [31:0]        px_raw_c, py_raw_c;
  logic               clip_c;
  logic [PX_W-1:0]    px_c;
  logic [PY_W-1:0]    py_c;

  // |v| > 1.0 in Q16.16; exactly +/-1.0 stays inside the view volume
  function automatic logic beyond_one(input logic signed [31:0] v);
    return (v > ONE) || (v < -ONE);
  endfunction

  assign accept_c = (state == IDLE) && valid_in;

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: fixed schedule, only IDLE waits on the input
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c) state_nxt = DIVIDE;
      DIVIDE:  if (cnt_r == LAST_STEP) state_nxt = MULT;
      MULT:    state_nxt = SCALE;
      SCALE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One restoring-division step; the 33-bit dividend 2^32 feeds a 1 on step 0
  always_comb begin
    trial_c   = {rem_r, (cnt_r == '0)};
    div_ge_c  = (trial_c >= {1'b0, w_r});
    rem_nxt_c = div_ge_c ? 32'(trial_c - {1'b0, w_r}) : trial_c[31:0];
  end

  // NDC = (c * q) >>> 16; q <= 1.0 when w >= 1.0, so 18 signed bits suffice
  always_comb begin
    recip_c  = near_r ? '0 : $signed(18'(quot_r));
    prod_x_c = 50'(x_r) * 50'(recip_c);
    prod_y_c = 50'(y_r) * 50'(recip_c);
    prod_z_c = 50'(z_r) * 50'(recip_c);
    ndc_x_c  = 32'(prod_x_c >>> 16);
    ndc_y_c  = 32'(prod_y_c >>> 16);
    ndc_z_c  = 32'(prod_z_c >>> 16);
  end

  // Viewport mapping with clamp of the +/-1.0 edge; y is flipped so 0 is the top row
  always_comb begin
    sum_x_c  = ndc_x_r + ONE;
    sum_y_c  = ONE - ndc_y_r;
    scl_x_c  = 48'(sum_x_c) * HALF_W;
    scl_y_c  = 48'(sum_y_c) * HALF_H;
    px_raw_c = 32'(scl_x_c >> 16);
    py_raw_c = 32'(scl_y_c >> 16);
    clip_c   = near_r || beyond_one(ndc_x_r) || beyond_one(ndc_y_r) || beyond_one(ndc_z_r);
    px_c     = clip_c ? '0 : PX_W'((px_raw_c > PX_MAX) ? PX_MAX : px_raw_c);
    py_c     = clip_c ? '0 : PY_W'((py_raw_c > PY_MAX) ? PY_MAX : py_raw_c);
  end

  // Datapath and output registers, sequenced by the FSM state
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x_r         <= '0;
      y_r         <= '0;
      z_r         <= '0;
      w_r         <= '0;
      near_r      <= 1'b0;
      rem_r       <= '0;
      quot_r      <= '0;
      cnt_r       <= '0;
      ndc_x_r     <= '0;
      ndc_y_r     <= '0;
      ndc_z_r     <= '0;
      ready_out   <= 1'b1;
      valid_out   <= 1'b0;
      px_out      <= '0;
      py_out      <= '0;
      depth_out   <= '0;
      clipped_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            x_r       <= $signed(vec_in[0]);
            y_r       <= $signed(vec_in[1]);
            z_r       <= $signed(vec_in[2]);
            w_r       <= vec_in[3];
            near_r    <= ($signed(vec_in[3]) < ONE);
            rem_r     <= '0;
            quot_r    <= '0;
            cnt_r     <= '0;
            ready_out <= 1'b0;
          end
        end
        DIVIDE: begin
          rem_r  <= rem_nxt_c;
          quot_r <= {quot_r[31:0], div_ge_c};
          cnt_r  <= cnt_r + CNT_W'(1);
        end
        MULT: begin
          ndc_x_r <= ndc_x_c;
          ndc_y_r <= ndc_y_c;
          ndc_z_r <= ndc_z_c;
        end
        SCALE: begin
          px_out      <= px_c;
          py_out      <= py_c;
          depth_out   <= clip_c ? '0 : ndc_z_r;
          clipped_out <= clip_c;
          valid_out   <= 1'b1;
          ready_out   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
